alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Parametrised, clocked successor to the processor's single-cycle 32-bit ALU.
- Keeps the existing logic/arithmetic op encodings.
- Adds unsigned compare, signed overflow, and iterative multiply/divide into HI/LO registers with MFHI/MFLO readback.
- Sits in the EX stage; the control unit issues Start and stalls on Busy.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
Start  input  1  issue request; sampled only when Busy=0
ALU_Ctl  input  4  operation code
A  input  WIDTH  operand A (rs)
B  input  WIDTH  operand B (rt/imm)
Output  output  WIDTH  registered result
Zero  output  1  high when Output==0
Overflow  output  1  signed overflow on ADD/SUB
DivZero  output  1  divide-by-zero flag, valid with Done
Illegal  output  1  unsupported ALU_Ctl, valid with Done
Busy  output  1  multi-cycle op in progress
Done  output  1  one-cycle pulse: result/flags valid

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on reset_n.
- Reset (reset_n=0 at a clk edge):
  - Output=0, Zero=1, Overflow=0, DivZero=0, Illegal=0, Busy=0, Done=0.
  - HI=0, LO=0, FSM=IDLE.
  - Reset mid-operation aborts it; no Done is produced.
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - 0111 SLT (signed), 0011 SLTU, 1100 NOR.
  - 1000 MULTU, 1001 MULT, 1010 DIVU, 1011 DIV.
  - 1101 MFHI, 1110 MFLO.
  - Any other code: Output=0, Illegal=1.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE, Start=1, single-cycle op (logic, ADD, SUB, SLT/SLTU, MFHI/MFLO, illegal):
  - Output and flags are registered at that edge.
  - Done=1 for the following cycle. Latency 1, Busy stays 0.
- IDLE, Start=1, MULT/MULTU/DIV/DIVU:
  - Operands are captured (absolute values for signed ops; result signs recorded), counter=0, Busy=1.
  - MUL/DIV run one shift-add / restoring-subtract step per cycle for WIDTH cycles, then enter FIX.
  - FIX applies sign correction and writes HI/LO:
    - MULT: HI:LO = 2*WIDTH-bit product.
    - DIV: LO = quotient, HI = remainder; remainder sign follows A, quotient truncates toward zero.
  - FIX also sets Output=LO, drops Busy and pulses Done. Total latency WIDTH+1 cycles from the Start edge.
- Start while Busy=1 is ignored (not queued). Inputs A/B/ALU_Ctl may change freely after capture.
- Done is high for exactly one cycle. Output and flags hold until the next accepted Start.
- Zero: continuous compare of the Output register.
- Overflow:
  - ADD: set if operand signs match and the result sign differs.
  - SUB: set if operand signs differ and the result sign differs from A.
  - Cleared by every other op.
- SLT/SLTU: Output = {WIDTH-1 zeros, compare bit}.
- Divide by zero (B=0):
  - Completes in 1 cycle without entering DIV.
  - LO = all ones, HI = A, Output = LO, DivZero=1.
- DIV special case: most-negative / -1 gives LO = most-negative, HI = 0, no flag.
- MFHI/MFLO issued in the cycle right after Done read the updated HI/LO.

Optional Feature:
- Macro ALU_MULTICYCLE_DIV_EN.
- Defined: DIV/DIVU behave as above.
- Undefined:
  - The divider datapath and the DIV state are omitted.
  - Codes 1010/1011 complete in 1 cycle with Illegal=1 and Output=0.
  - HI/LO are unchanged and DivZero stays 0.

Test Plan:
- ADD A=0x7FFFFFFF, B=1 -> next cycle: Output=0x80000000, Overflow=1, Zero=0, Done=1 for one cycle, Busy=0.
- SUB A=5, B=5 -> Output=0, Zero=1, Overflow=0. SLT A=0xFFFFFFFF, B=1 -> Output=1. SLTU same operands -> Output=0.
- MULT A=0xFFFFFFFD (-3), B=7 -> Busy high for 32 cycles, Done 33 cycles after Start, HI=0xFFFFFFFF, LO=0xFFFFFFEB. MFLO next -> Output=0xFFFFFFEB.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 -> Done after 1 cycle, DivZero=1, LO=0xFFFFFFFF, HI=7.
- Start pulsed with ADD during the 10th cycle of a MULTU -> ignored, MULTU result unchanged. Then reset_n=0 mid-MULTU -> next edge: Busy=0, HI=LO=0, Output=0, Zero=1, no Done.
- Build without ALU_MULTICYCLE_DIV_EN, issue DIV 0x10/2 -> Done after 1 cycle, Illegal=1, Output=0, HI/LO unchanged.

Source files
------------

// File: rtl/alu_multicycle.sv
// Clocked EX-stage ALU: single-cycle logic/arith/compare plus iterative multiply/divide into HI/LO.
// Define ALU_MULTICYCLE_DIV_EN to build the divider; without it DIV/DIVU complete as Illegal.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Start,
    input  logic [3:0]       ALU_Ctl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Output,
    output logic             Zero,
    output logic             Overflow,
    output logic             DivZero,
    output logic             Illegal,
    output logic             Busy,
    output logic             Done
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_MULT  = 4'b1001;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;
`ifdef ALU_MULTICYCLE_DIV_EN
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIX} state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               neg_lo_q, neg_lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, out_q, out_d;
    logic               ovf_q, ovf_d, dz_q, dz_d, ill_q, ill_d, done_q, done_d;

    logic [WIDTH-1:0]   add_res, sub_res, a_abs, b_abs;
    logic               add_ovf, sub_ovf, slt_bit, sltu_bit, sgn;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, fix_prod;

    assign add_res  = A + B;
    assign sub_res  = A - B;
    assign add_ovf  = (A[WIDTH-1] == B[WIDTH-1]) && (add_res[WIDTH-1] != A[WIDTH-1]);
    assign sub_ovf  = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);
    assign slt_bit  = $signed(A) < $signed(B);
    assign sltu_bit = A < B;
    assign a_abs    = A[WIDTH-1] ? -A : A;
    assign b_abs    = B[WIDTH-1] ? -B : B;
    // Bit 0 of the opcode separates MULT/DIV (signed) from MULTU/DIVU.
    assign sgn      = ALU_Ctl[0];

    // Shift-add step: upper half accumulates the multiplicand, lower half shifts the multiplier out.
    assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, p_q[WIDTH-1:1]};
    assign fix_prod = neg_lo_q ? -mul_next : mul_next;

`ifdef ALU_MULTICYCLE_DIV_EN
    logic               neg_hi_q, neg_hi_d, is_div_q, is_div_d;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_sub, quo, rem;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    // Restoring step: remainder in the upper half, dividend shifts out / quotient shifts in below.
    assign div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, m_q};
    assign div_sub   = div_shift[WIDTH-1:0] - m_q;
    assign div_next  = div_ge ? {div_sub, p_q[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
    assign quo       = neg_lo_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    assign rem       = neg_hi_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        m_d      = m_q;
        neg_lo_d = neg_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        out_d    = out_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        ill_d    = ill_q;
        done_d   = 1'b0;
`ifdef ALU_MULTICYCLE_DIV_EN
        neg_hi_d = neg_hi_q;
        is_div_d = is_div_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    done_d = 1'b1;
                    ovf_d  = 1'b0;
                    dz_d   = 1'b0;
                    ill_d  = 1'b0;
                    case (ALU_Ctl)
                        OP_AND:  out_d = A & B;
                        OP_OR:   out_d = A | B;
                        OP_NOR:  out_d = ~(A | B);
                        OP_ADD:  begin out_d = add_res; ovf_d = add_ovf; end
                        OP_SUB:  begin out_d = sub_res; ovf_d = sub_ovf; end
                        OP_SLT:  out_d = WIDTH'(slt_bit);
                        OP_SLTU: out_d = WIDTH'(sltu_bit);
                        OP_MFHI: out_d = hi_q;
                        OP_MFLO: out_d = lo_q;
                        OP_MULTU, OP_MULT: begin
                            done_d   = 1'b0;
                            state_d  = S_MUL;
                            cnt_d    = '0;
                            p_d      = {{WIDTH{1'b0}}, sgn ? b_abs : B};
                            m_d      = sgn ? a_abs : A;
                            neg_lo_d = sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef ALU_MULTICYCLE_DIV_EN
                            is_div_d = 1'b0;
`endif
                        end
`ifdef ALU_MULTICYCLE_DIV_EN
                        OP_DIVU, OP_DIV: begin
                            if (B == '0) begin
                                lo_d  = '1;
                                hi_d  = A;
                                out_d = '1;
                                dz_d  = 1'b1;
                            end else begin
                                done_d   = 1'b0;
                                state_d  = S_DIV;
                                cnt_d    = '0;
                                p_d      = {{WIDTH{1'b0}}, sgn ? a_abs : A};
                                m_d      = sgn ? b_abs : B;
                                neg_lo_d = sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
                                neg_hi_d = sgn && A[WIDTH-1];
                                is_div_d = 1'b1;
                            end
                        end
`endif
                        default: begin
                            out_d = '0;
                            ill_d = 1'b1;
                        end
                    endcase
                end
            end
            // The last of the WIDTH steps is folded into FIX so Done lands WIDTH+1 cycles after Start.
            S_MUL: begin
                p_d   = mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 2)) state_d = S_FIX;
            end
`ifdef ALU_MULTICYCLE_DIV_EN
            S_DIV: begin
                p_d   = div_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 2)) state_d = S_FIX;
            end
`endif
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                ovf_d   = 1'b0;
                dz_d    = 1'b0;
                ill_d   = 1'b0;
`ifdef ALU_MULTICYCLE_DIV_EN
                if (is_div_q) begin
                    hi_d  = rem;
                    lo_d  = quo;
                    out_d = quo;
                end else begin
                    hi_d  = fix_prod[2*WIDTH-1:WIDTH];
                    lo_d  = fix_prod[WIDTH-1:0];
                    out_d = fix_prod[WIDTH-1:0];
                end
`else
                hi_d  = fix_prod[2*WIDTH-1:WIDTH];
                lo_d  = fix_prod[WIDTH-1:0];
                out_d = fix_prod[WIDTH-1:0];
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            m_q      <= '0;
            neg_lo_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            ill_q    <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_MULTICYCLE_DIV_EN
            neg_hi_q <= 1'b0;
            is_div_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            m_q      <= m_d;
            neg_lo_q <= neg_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
            ill_q    <= ill_d;
            done_q   <= done_d;
`ifdef ALU_MULTICYCLE_DIV_EN
            neg_hi_q <= neg_hi_d;
            is_div_q <= is_div_d;
`endif
        end
    end

    assign Output   = out_q;
    assign Zero     = (out_q == '0);
    assign Overflow = ovf_q;
    assign DivZero  = dz_q;
    assign Illegal  = ill_q;
    assign Busy     = (state_q != S_IDLE);
    assign Done     = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed and random ops checked against a 64-bit arithmetic model.
`timescale 1ns/1ps
module tb_alu_multicycle;
    localparam int W    = 32;
    localparam int MLAT = W + 1;
    localparam int ND   = 26;

    logic         clk = 1'b0;
    logic         reset_n, Start;
    logic [3:0]   ALU_Ctl;
    logic [W-1:0] A, B, Output;
    logic         Zero, Overflow, DivZero, Illegal, Busy, Done;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .Start(Start), .ALU_Ctl(ALU_Ctl), .A(A), .B(B),
        .Output(Output), .Zero(Zero), .Overflow(Overflow), .DivZero(DivZero),
        .Illegal(Illegal), .Busy(Busy), .Done(Done)
    );

    logic [3:0]   d_op [ND] = '{4'b0010, 4'b0110, 4'b0111, 4'b0011, 4'b0000, 4'b0001, 4'b1100,
                                4'b0110, 4'b0010, 4'b1001, 4'b1110, 4'b1101, 4'b1000, 4'b1101,
                                4'b1011, 4'b1110, 4'b1101, 4'b1010, 4'b1101, 4'b1011, 4'b1101,
                                4'b1011, 4'b1110, 4'b1101, 4'b0100, 4'b1111};
    logic [W-1:0] d_a [ND] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F01234,
                               32'hF0F01234, 32'h0, 32'h80000000, 32'h80000000, 32'hFFFFFFFD,
                               32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFF9, 32'h0, 32'h0,
                               32'd7, 32'h0, 32'h80000000, 32'h0, 32'h10, 32'h0, 32'h0,
                               32'h12345678, 32'h9ABCDEF0};
    logic [W-1:0] d_b [ND] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'hFF00FF00, 32'h0F0F0001, 32'h0,
                               32'd1, 32'h80000000, 32'd7, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0,
                               32'd2, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'd2,
                               32'h0, 32'h0, 32'h1, 32'h2};

    // Reference model: exact arithmetic in 64 bits, results and HI/LO taken from the op's meaning.
    task automatic ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] o, output logic ov, output logic dz,
                          output logic il, output int lat);
        longint       sa, sb, s;
        logic [63:0]  pr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        o = '0; ov = 1'b0; dz = 1'b0; il = 1'b0; lat = 1;
        case (op)
            4'b0000: o = a & b;
            4'b0001: o = a | b;
            4'b1100: o = ~(a | b);
            4'b0010: begin s = sa + sb; o = s[W-1:0]; ov = (s != longint'($signed(o))); end
            4'b0110: begin s = sa - sb; o = s[W-1:0]; ov = (s != longint'($signed(o))); end
            4'b0111: o = (sa < sb) ? 32'd1 : 32'd0;
            4'b0011: o = (a < b) ? 32'd1 : 32'd0;
            4'b1101: o = m_hi;
            4'b1110: o = m_lo;
            4'b1000: begin pr = {32'b0, a} * {32'b0, b}; m_hi = pr[63:32]; m_lo = pr[31:0]; o = m_lo; lat = MLAT; end
            4'b1001: begin pr = sa * sb; m_hi = pr[63:32]; m_lo = pr[31:0]; o = m_lo; lat = MLAT; end
`ifdef ALU_MULTICYCLE_DIV_EN
            4'b1010, 4'b1011: begin
                if (b == '0) begin
                    m_lo = '1; m_hi = a; o = m_lo; dz = 1'b1;
                end else if (op == 4'b1010) begin
                    m_lo = a / b; m_hi = a % b; o = m_lo; lat = MLAT;
                end else begin
                    pr = sa / sb; m_lo = pr[31:0];
                    pr = sa % sb; m_hi = pr[31:0];
                    o = m_lo; lat = MLAT;
                end
            end
`endif
            default: il = 1'b1;
        endcase
    endtask

    // Issue one op at the current falling edge and wait (bounded) for Done.
    task automatic go(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      output int lat, output logic busy_ok);
        Start = 1'b1; ALU_Ctl = op; A = a; B = b;
        @(negedge clk);
        Start = 1'b0; ALU_Ctl = 4'($urandom); A = $urandom; B = $urandom;
        lat = 1; busy_ok = 1'b1;
        while (!Done && lat < 100) begin
            if (!Busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (Busy) busy_ok = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; Start = 1'b0; ALU_Ctl = '0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({Output, Zero, Overflow, DivZero, Illegal, Busy, Done} !== {32'h0, 1'b1, 5'b0}) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h",
                     {Output, Zero, Overflow, DivZero, Illegal, Busy, Done}, {32'h0, 1'b1, 5'b0});
        end
        reset_n = 1'b1;
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_directed();
        logic [W-1:0] eo; logic eov, edz, eil, bok; int elat, lat;
        for (int i = 0; i < ND; i++) begin
            ref_op(d_op[i], d_a[i], d_b[i], eo, eov, edz, eil, elat);
            go(d_op[i], d_a[i], d_b[i], lat, bok);
            checks++;
            if ({Output, Overflow, DivZero, Illegal, Zero} !== {eo, eov, edz, eil, (eo == '0)}) begin
                errors++;
                $display("FAIL directed[%0d] result op=%b got=%h want=%h", i, d_op[i],
                         {Output, Overflow, DivZero, Illegal, Zero}, {eo, eov, edz, eil, (eo == '0)});
            end
            checks++;
            if (lat !== elat) begin
                errors++;
                $display("FAIL directed[%0d] latency op=%b got=%0d want=%0d", i, d_op[i], lat, elat);
            end
            checks++;
            if (bok !== 1'b1) begin
                errors++;
                $display("FAIL directed[%0d] busy op=%b got=%b want=1", i, d_op[i], bok);
            end
        end
    endtask

    task automatic test_done_pulse();
        logic [W-1:0] eo; logic eov, edz, eil, bok; int elat, lat;
        ref_op(4'b1001, 32'hFFFFFFFD, 32'd7, eo, eov, edz, eil, elat);
        go(4'b1001, 32'hFFFFFFFD, 32'd7, lat, bok);
        @(negedge clk);
        checks++;
        if ({Done, Busy, Output} !== {1'b0, 1'b0, eo}) begin
            errors++;
            $display("FAIL done_pulse got=%h want=%h", {Done, Busy, Output}, {1'b0, 1'b0, eo});
        end
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] a, b, eo; logic eov, edz, eil; int elat, cyc;
        a = $urandom; b = $urandom;
        ref_op(4'b1000, a, b, eo, eov, edz, eil, elat);
        Start = 1'b1; ALU_Ctl = 4'b1000; A = a; B = b;
        @(negedge clk);
        Start = 1'b0;
        cyc = 1;
        while (!Done && cyc < 100) begin
            if (cyc == 10) begin Start = 1'b1; ALU_Ctl = 4'b0010; A = 32'd1; B = 32'd2; end
            else Start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        Start = 1'b0;
        checks++;
        if (cyc !== elat) begin
            errors++;
            $display("FAIL busy_ignore latency got=%0d want=%0d", cyc, elat);
        end
        checks++;
        if ({Output, Overflow, DivZero, Illegal} !== {eo, eov, edz, eil}) begin
            errors++;
            $display("FAIL busy_ignore result got=%h want=%h", {Output, Overflow, DivZero, Illegal}, {eo, eov, edz, eil});
        end
        @(negedge clk);
        checks++;
        if ({Done, Output} !== {1'b0, eo}) begin
            errors++;
            $display("FAIL busy_ignore stray_start got=%h want=%h", {Done, Output}, {1'b0, eo});
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] eo; logic eov, edz, eil, bok, saw; int elat, lat;
        ref_op(4'b1000, 32'h1234567, 32'h89ABC, eo, eov, edz, eil, elat);
        go(4'b1000, 32'h1234567, 32'h89ABC, lat, bok);
        ref_op(4'b0010, 32'd1, 32'd1, eo, eov, edz, eil, elat);
        go(4'b0010, 32'd1, 32'd1, lat, bok);
        Start = 1'b1; ALU_Ctl = 4'b1000; A = 32'hDEAD; B = 32'hBEEF;
        @(negedge clk);
        Start = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({Busy, Done, Output, Zero} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid state got=%h want=%h", {Busy, Done, Output, Zero}, {1'b0, 1'b0, 32'h0, 1'b1});
        end
        reset_n = 1'b1;
        m_hi = '0; m_lo = '0;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (Done) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid stray_done got=%b want=0", saw);
        end
        for (int k = 0; k < 2; k++) begin
            ref_op(k == 0 ? 4'b1101 : 4'b1110, '0, '0, eo, eov, edz, eil, elat);
            go(k == 0 ? 4'b1101 : 4'b1110, '0, '0, lat, bok);
            checks++;
            if (Output !== eo) begin
                errors++;
                $display("FAIL reset_mid hilo[%0d] got=%h want=%h", k, Output, eo);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, eo; logic [3:0] op; logic eov, edz, eil, bok; int elat, lat;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a = pick(); b = pick();
            ref_op(op, a, b, eo, eov, edz, eil, elat);
            go(op, a, b, lat, bok);
            checks++;
            if ({Output, Overflow, DivZero, Illegal, Zero, lat == elat, bok} !==
                {eo, eov, edz, eil, (eo == '0), 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL random[%0d] op=%b a=%h b=%h got=%h lat=%0d busy=%b want=%h lat=%0d",
                         i, op, a, b, {Output, Overflow, DivZero, Illegal, Zero}, lat, bok,
                         {eo, eov, edz, eil, (eo == '0)}, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_done_pulse();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
